// File: rtl/lc_request_assembler.sv
// lc_request_assembler: assembles a header plus payload words into a 256-bit lifecycle ID and issues a one-cycle request
module lc_request_assembler #(
  parameter int WORD_W          = 32,
  parameter int ID_WIDTH        = 256,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int COOLDOWN_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                host_valid,
  input  logic [WORD_W-1:0]   host_data,
  output logic                host_ready,
  output logic [ID_WIDTH-1:0] lc_transition_id,
  output logic                lc_transition_request_in,
  output logic [ID_WIDTH-1:0] lc_authentication_id,
  output logic                lc_authentication_valid,
  output logic                busy,
  output logic                err_illegal_op,
  output logic                err_timeout,
  output logic [7:0]          req_count
);
  localparam int NWORDS = ID_WIDTH / WORD_W;
  localparam int IW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] CD_LAST = COOLDOWN_CYCLES > 0 ? 32'(COOLDOWN_CYCLES - 1) : 32'd0;
  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, COOLDOWN} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [31:0] tmo;
  logic [31:0] cd;
  logic is_auth;
  logic hs;
  logic [ID_WIDTH-1:0] shadow;
  logic [ID_WIDTH-1:0] merged;
  assign host_ready = state == IDLE || state == COLLECT;
  assign busy = state != IDLE;
  assign hs = host_valid && host_ready;
  // shadow with the current word folded in, so the final word can publish on its own handshake edge
  always_comb begin
    merged = shadow;
    merged[WORD_W*idx +: WORD_W] = host_data;
  end
  // control FSM with registered pulses, published IDs and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx <= '0;
      tmo <= '0;
      cd <= '0;
      is_auth <= 1'b0;
      shadow <= '0;
      lc_transition_id <= '0;
      lc_transition_request_in <= 1'b0;
      lc_authentication_id <= '0;
      lc_authentication_valid <= 1'b0;
      err_illegal_op <= 1'b0;
      err_timeout <= 1'b0;
      req_count <= '0;
    end else begin
      lc_transition_request_in <= 1'b0;
      lc_authentication_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            if (host_data[1:0] == 2'b01 || host_data[1:0] == 2'b10) begin
              is_auth <= host_data[1];
              err_illegal_op <= 1'b0;
              err_timeout <= 1'b0;
              idx <= '0;
              tmo <= '0;
              shadow <= '0;
              state <= COLLECT;
            end else begin
              err_illegal_op <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (hs) begin
            shadow <= merged;
            tmo <= '0;
            idx <= idx + 1'b1;
            if (idx == IW'(NWORDS - 1)) begin
              state <= ISSUE;
              if (is_auth) begin
                lc_authentication_id <= merged;
                lc_authentication_valid <= 1'b1;
              end else begin
                lc_transition_id <= merged;
                lc_transition_request_in <= 1'b1;
              end
              if (req_count != 8'hff) req_count <= req_count + 8'd1;
            end
          end else if (tmo == TMO_LAST) begin
            state <= IDLE;
            err_timeout <= 1'b1;
            shadow <= '0;
          end else begin
            tmo <= tmo + 32'd1;
          end
        end
        ISSUE: begin
          cd <= '0;
          state <= COOLDOWN_CYCLES > 0 ? COOLDOWN : IDLE;
        end
        COOLDOWN: begin
          if (cd == CD_LAST) state <= IDLE;
          else cd <= cd + 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lc_request_assembler.sv
// tb_lc_request_assembler: directed checks of assembly, pulses, cooldown, timeout, illegal opcode, reset and saturation
module tb_lc_request_assembler;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic host_valid = 1'b0;
  logic [31:0] host_data = '0;
  logic host_ready;
  logic [255:0] lc_transition_id;
  logic lc_transition_request_in;
  logic [255:0] lc_authentication_id;
  logic lc_authentication_valid;
  logic busy;
  logic err_illegal_op;
  logic err_timeout;
  logic [7:0] req_count;
  int errors = 0;
  int checks = 0;
  logic [255:0] id1;
  logic [255:0] id_a5;
  int n;
  lc_request_assembler #(
    .WORD_W(32), .ID_WIDTH(256), .TIMEOUT_CYCLES(8), .COOLDOWN_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .host_valid(host_valid), .host_data(host_data),
    .host_ready(host_ready), .lc_transition_id(lc_transition_id),
    .lc_transition_request_in(lc_transition_request_in),
    .lc_authentication_id(lc_authentication_id),
    .lc_authentication_valid(lc_authentication_valid), .busy(busy),
    .err_illegal_op(err_illegal_op), .err_timeout(err_timeout), .req_count(req_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [31:0] w);
    int k = 0;
    host_valid = 1'b1;
    host_data = w;
    while (!host_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!host_ready) check("send_ready_timeout", 0, 1);
    @(negedge clk);
    host_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("wait_idle_timeout", 1, 0);
  endtask
  initial begin
    for (int i = 0; i < 8; i++) begin
      id1[32*i +: 32] = 32'h11111111 * (i + 1);
      id_a5[32*i +: 32] = 32'hA5A5A5A5;
    end
    repeat (2) @(negedge clk);
    check("rst_ready", host_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tid", lc_transition_id, 0);
    check("rst_cnt", req_count, 0);
    rst = 1'b1;
    @(negedge clk);
    send(32'h1);
    check("hdr_busy", busy, 1);
    for (int i = 0; i < 8; i++) send(32'h11111111 * (i + 1));
    check("t_pulse", lc_transition_request_in, 1);
    check("t_auth_pulse", lc_authentication_valid, 0);
    check("t_id", lc_transition_id, id1);
    check("t_auth_id", lc_authentication_id, 0);
    check("t_cnt", req_count, 1);
    check("issue_ready", host_ready, 0);
    host_valid = 1'b1;
    host_data = 32'h2;
    n = 1;
    @(negedge clk);
    check("t_pulse_drop", lc_transition_request_in, 0);
    while (!host_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("cooldown_len", n, 5);
    @(negedge clk);
    host_valid = 1'b0;
    check("cd_hdr_busy", busy, 1);
    check("cd_hdr_ready", host_ready, 1);
    for (int i = 0; i < 8; i++) begin
      send(32'hA5A5A5A5);
      if (i < 7) repeat (3) @(negedge clk);
    end
    check("a_pulse", lc_authentication_valid, 1);
    check("a_t_pulse", lc_transition_request_in, 0);
    check("a_id", lc_authentication_id, id_a5);
    check("a_tid_kept", lc_transition_id, id1);
    check("a_no_tmo", err_timeout, 0);
    check("a_cnt", req_count, 2);
    @(negedge clk);
    check("a_pulse_drop", lc_authentication_valid, 0);
    wait_idle();
    send(32'h1);
    for (int i = 0; i < 3; i++) send(32'hDEADBEEF);
    repeat (7) @(negedge clk);
    check("tmo_not_yet", busy, 1);
    @(negedge clk);
    check("tmo_idle", busy, 0);
    check("tmo_flag", err_timeout, 1);
    check("tmo_tid_kept", lc_transition_id, id1);
    send(32'h1);
    check("tmo_cleared", err_timeout, 0);
    repeat (8) @(negedge clk);
    check("tmo2_flag", err_timeout, 1);
    send(32'h3);
    check("ill_flag", err_illegal_op, 1);
    check("ill_busy", busy, 0);
    send(32'hFFFFFFF0);
    check("ill0_flag", err_illegal_op, 1);
    check("ill0_busy", busy, 0);
    send(32'h1);
    check("ill_cleared", err_illegal_op, 0);
    check("ill_hdr_busy", busy, 1);
    for (int i = 0; i < 5; i++) send(32'h12345678);
    #2 rst = 1'b0;
    #1;
    check("arst_ready", host_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_tid", lc_transition_id, 0);
    check("arst_aid", lc_authentication_id, 0);
    check("arst_cnt", req_count, 0);
    check("arst_err", {err_illegal_op, err_timeout}, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send(32'h2);
    for (int i = 0; i < 8; i++) send(32'h11111111 * (i + 1));
    check("post_rst_aid", lc_authentication_id, id1);
    check("post_rst_tid", lc_transition_id, 0);
    wait_idle();
    for (int r = 1; r < 260; r++) begin
      send((r % 2) ? 32'h1 : 32'h2);
      for (int i = 0; i < 8; i++) send(32'(r * 8 + i));
      if (r == 254) check("cnt_254", req_count, 255);
      wait_idle();
    end
    check("cnt_sat", req_count, 255);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lc_request_assembler.md
Name: lc_request_assembler

Overview:
- Host-facing front end that feeds the lifecycle inputs of the MCSE control unit: lc_transition_id/lc_transition_request_in and lc_authentication_id/lc_authentication_valid.
- Accepts a header word plus ID_WIDTH/WORD_W payload words over a 32-bit valid/ready stream and assembles them into a 256-bit identifier.
- Issues a single-cycle request pulse with the identifier held stable, then enforces a cooldown.
- Aborts stalled transfers and flags protocol errors.

Parameters:
- WORD_W, 32, host word width.
- ID_WIDTH, 256, identifier width; must be an integer multiple of WORD_W (NWORDS = ID_WIDTH/WORD_W = 8).
- TIMEOUT_CYCLES, 1024, consecutive no-handshake cycles in COLLECT before abort; must be ≥ 1.
- COOLDOWN_CYCLES, 16, cycles after an issue during which no new header is accepted; 0 is allowed.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low.
- host_valid  input  1  host word valid.
- host_data  input  WORD_W  host word.
- host_ready  output  1  block can accept a word.
- lc_transition_id  output  ID_WIDTH  assembled transition ID; held between updates.
- lc_transition_request_in  output  1  one-cycle transition request pulse.
- lc_authentication_id  output  ID_WIDTH  assembled authentication ID; held between updates.
- lc_authentication_valid  output  1  one-cycle authentication pulse.
- busy  output  1  state is not IDLE.
- err_illegal_op  output  1  sticky: illegal header opcode received.
- err_timeout  output  1  sticky: payload collection aborted.
- req_count  output  8  saturating count of issued requests.

Behaviour:
- **Handshake:** a word transfers on a rising clk edge where host_valid && host_ready. host_ready is decoded from state: 1 in IDLE and COLLECT, 0 in ISSUE and COOLDOWN.
- **Reset (rst=0, asynchronous):**
  - state=IDLE.
  - All ID registers, pulses, error flags, req_count and internal counters = 0.
  - busy=0, host_ready=1.
- **IDLE:**
  - A handshake consumes a header; opcode = host_data[1:0], host_data[31:2] ignored.
  - Opcode 01 (transition) or 10 (authentication): latch the opcode, clear both error flags, word index=0, timeout counter=0, go to COLLECT.
  - Opcode 00 or 11: set err_illegal_op, stay in IDLE. No other state changes.
- **COLLECT:**
  - Each handshake writes host_data into shadow[WORD_W*idx +: WORD_W] (word 0 = bits [31:0]), increments idx and clears the timeout counter.
  - A cycle without a handshake increments the timeout counter.
  - When the counter reaches TIMEOUT_CYCLES: go to IDLE, set err_timeout, discard the shadow. Published IDs are unchanged.
  - A handshake on the cycle the counter would reach the limit wins; no abort occurs.
  - The handshake of word NWORDS-1 goes to ISSUE.
- **ISSUE (exactly 1 cycle, registered outputs, visible the cycle after the last payload handshake):**
  - Transition: lc_transition_id <= full shadow, lc_transition_request_in=1.
  - Authentication: lc_authentication_id <= full shadow, lc_authentication_valid=1.
  - The other ID register and its pulse are untouched.
  - req_count increments and saturates at 255.
  - Next state is COOLDOWN if COOLDOWN_CYCLES>0, else IDLE.
- **COOLDOWN:** stay exactly COOLDOWN_CYCLES cycles with host_ready=0, then IDLE.
- **Pulses:** high only in the ISSUE cycle. Never both high. Never high in consecutive cycles.
- **ID stability:** IDs change only on the ISSUE edge. A partial, aborted or reset-interrupted transfer never alters a published ID.
- **Reset mid-operation:** returns to IDLE immediately. Any in-flight pulse drops and the shadow is cleared.
- **Latency:** header accept to pulse = NWORDS+1 cycles minimum, i.e. 9 at defaults with back-to-back valid.

Test Plan:
- **Transition request:** header 0x00000001, then words 0x11111111..0x88888888 back-to-back → the cycle after the 8th handshake has lc_transition_request_in=1 for one cycle. lc_transition_id = 0x88888888_77777777_..._11111111, req_count=1, lc_authentication_id stays 0.
- **Authentication request with gaps:** header 0x00000002, 8 words 0xA5A5A5A5 with 3 idle cycles between words (TIMEOUT_CYCLES=8) → lc_authentication_valid pulses once, lc_authentication_id = all 0xA5, no err_timeout.
- **Timeout:** TIMEOUT_CYCLES=8, header 0x1, 3 words, then host_valid=0 → state IDLE after the 8th idle cycle, err_timeout=1, lc_transition_id unchanged. A following legal header clears err_timeout.
- **Illegal opcode:** header 0x00000003 → one handshake, err_illegal_op=1, busy stays 0. A following header 0x1 clears err_illegal_op.
- **Cooldown:** COOLDOWN_CYCLES=4, complete a request, hold host_valid=1 with header 0x2 → host_ready=0 for ISSUE + 4 cycles, and the header is accepted on the 6th cycle after the pulse-preceding edge (the edge of the last payload handshake).
- **Reset and saturation:** assert rst after 5 payload words → all outputs 0 and host_ready=1 asynchronously. Issue 260 requests → req_count saturates at 255.
